// File: rtl/astropix_layers_frame_arbiter_if.sv
// Byte-stream bundle shared by the layer inputs (LANES wide) and the merged output (LANES=1).
// Handshake: a byte moves on a rising clk edge where tvalid && tready; the source holds tdata/tlast/tdest until then.
interface astropix_layers_frame_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 8
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [DEST_WIDTH-1:0]       tdest;

  modport master (output tdata, tvalid, tlast, tdest, input tready);
  modport slave  (input tdata, tvalid, tlast, tdest, output tready);
endinterface

// File: rtl/astropix_layers_frame_arbiter.sv
// Round-robin frame arbiter: merges per-layer LEN-prefixed byte frames into one stream,
// holding each grant for a whole frame and checking tlast position against LEN.
module astropix_layers_frame_arbiter #(
  parameter int NUM_LAYERS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  astropix_layers_frame_arbiter_if.slave  s_axis,
  astropix_layers_frame_arbiter_if.master m_axis,
  input  logic [NUM_LAYERS-1:0]           cfg_layer_enable,
  output logic                            stat_frame_forwarded,
  output logic                            stat_length_error,
  output logic                            status_grant_active,
  output logic                            dbg_state
);

  localparam int GW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           ptr_q;
  logic [GW-1:0]           pick;
  logic                    found;
  int                      idx;

  logic                    first_byte_q;
  logic                    ovr_flagged_q;
  logic [7:0]              rem_q;

  logic                    out_free;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    accept;
  logic                    len_err;

  logic [DATA_WIDTH-1:0]   m_data_q;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic [DEST_WIDTH-1:0]   m_dest_q;

  // Round-robin search starting one past the last served layer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_LAYERS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_LAYERS) idx = idx - NUM_LAYERS;
      if (!found && s_axis.tvalid[idx] && cfg_layer_enable[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    sel_valid = s_axis.tvalid[grant_q];
    sel_last  = s_axis.tlast[grant_q];
    sel_data  = s_axis.tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Ready follows the output register so a full, stalled register blocks the upstream.
  always_comb begin
    out_free      = !m_valid_q || m_axis.tready[0];
    s_axis.tready = '0;
    if (state_q == FRAME) s_axis.tready[grant_q] = out_free;
    accept = (state_q == FRAME) && sel_valid && out_free;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (found) state_d = FRAME;
      FRAME: if (accept && sel_last) state_d = IDLE;
    endcase
  end

  // rem_q counts bytes still owed after the LEN byte; overrun is reported once per frame.
  always_comb begin
    len_err = 1'b0;
    if (accept) begin
      if (first_byte_q)         len_err = sel_last && (sel_data[7:0] != 8'd0);
      else if (sel_last)        len_err = (rem_q != 8'd1);
      else if (rem_q == 8'd0)   len_err = !ovr_flagged_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= IDLE;
      ptr_q                <= GW'(NUM_LAYERS - 1);
      grant_q              <= '0;
      first_byte_q         <= 1'b1;
      ovr_flagged_q        <= 1'b0;
      rem_q                <= 8'd0;
      stat_frame_forwarded <= 1'b0;
      stat_length_error    <= 1'b0;
    end else begin
      state_q              <= state_d;
      stat_frame_forwarded <= accept && sel_last;
      stat_length_error    <= len_err;
      if (state_q == IDLE && found) begin
        grant_q       <= pick;
        first_byte_q  <= 1'b1;
        ovr_flagged_q <= 1'b0;
      end
      if (accept) begin
        if (first_byte_q) begin
          rem_q        <= sel_data[7:0];
          first_byte_q <= 1'b0;
        end else if (rem_q != 8'd0) begin
          rem_q <= rem_q - 8'd1;
        end else if (!sel_last) begin
          ovr_flagged_q <= 1'b1;
        end
        if (sel_last) ptr_q <= grant_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_dest_q  <= '0;
    end else if (accept) begin
      m_data_q  <= sel_data;
      m_valid_q <= 1'b1;
      m_last_q  <= sel_last;
      m_dest_q  <= DEST_WIDTH'(grant_q);
    end else if (m_axis.tready[0]) begin
      m_valid_q <= 1'b0;
    end
  end

  always_comb begin
    m_axis.tdata        = m_data_q;
    m_axis.tvalid[0]    = m_valid_q;
    m_axis.tlast[0]     = m_last_q;
    m_axis.tdest        = m_dest_q;
    status_grant_active = (state_q == FRAME);
    dbg_state           = state_q;
  end

endmodule

// File: tb/tb_astropix_layers_frame_arbiter.sv
// Directed bench for the frame arbiter: per-layer source queues, an expected-output queue, one task per scenario.
module tb_astropix_layers_frame_arbiter;
  localparam int NL = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  astropix_layers_frame_arbiter_if #(.LANES(NL), .DATA_WIDTH(8), .DEST_WIDTH(8)) s_axis ();
  astropix_layers_frame_arbiter_if #(.LANES(1),  .DATA_WIDTH(8), .DEST_WIDTH(8)) m_axis ();

  logic [NL-1:0] cfg_layer_enable;
  logic          stat_frame_forwarded;
  logic          stat_length_error;
  logic          status_grant_active;
  logic          dbg_state;

  astropix_layers_frame_arbiter #(.NUM_LAYERS(NL), .DATA_WIDTH(8), .DEST_WIDTH(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis               (s_axis),
    .m_axis               (m_axis),
    .cfg_layer_enable     (cfg_layer_enable),
    .stat_frame_forwarded (stat_frame_forwarded),
    .stat_length_error    (stat_length_error),
    .status_grant_active  (status_grant_active),
    .dbg_state            (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0]  src_q [NL][$];
  logic [16:0] exp_q [$];

  logic [NL-1:0] s_hs = '0;
  logic          m_hs = 1'b0;
  logic [7:0]    m_data_s, m_dest_s, held_data;
  logic          m_last_s, held_last;
  logic          stalled_prev = 1'b0;
  bit            bp_mode = 0, gap_chk = 0, mask_chk = 0;
  bit            have_prev = 0, prev_last = 0;
  int            cyc = 0, prev_cyc = 0;
  int            fwd_cnt = 0, err_cnt = 0, l2_taken = 0;

  // driver tasks
  task automatic push_byte(input int layer, input logic [7:0] data, input logic last, input bit with_exp);
    src_q[layer].push_back({last, data});
    if (with_exp) exp_q.push_back({8'(layer), last, data});
  endtask

  task automatic push_frame(input int layer, input int n, input logic [7:0] base, input bit with_exp);
    push_byte(layer, 8'(n - 1), n == 1, with_exp);
    for (int k = 1; k < n; k++) push_byte(layer, base + 8'(k), k == n - 1, with_exp);
  endtask

  // One clock: retire last edge's handshakes, score output, drive next inputs, sample.
  task automatic step();
    logic [16:0] e;
    int exp_gap;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (s_hs[i]) begin
        void'(src_q[i].pop_front());
        if (i == 2) l2_taken++;
      end
    end
    if (m_hs) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_extra got dest=%0d last=%0b data=%h required nothing", m_dest_s, m_last_s, m_data_s);
      end else begin
        e = exp_q.pop_front();
        if ({m_dest_s, m_last_s, m_data_s} !== e) begin
          bad++;
          $display("FAIL out_byte got dest=%0d last=%0b data=%h required dest=%0d last=%0b data=%h",
                   m_dest_s, m_last_s, m_data_s, e[16:9], e[8], e[7:0]);
        end
      end
      if (gap_chk) begin
        if (have_prev) begin
          exp_gap = prev_last ? 2 : 1;
          total++;
          if (cyc - prev_cyc != exp_gap) begin
            bad++;
            $display("FAIL out_gap got=%0d required=%0d", cyc - prev_cyc, exp_gap);
          end
        end
        have_prev = 1;
        prev_cyc  = cyc;
        prev_last = m_last_s;
      end
    end
    m_axis.tready[0] = bp_mode ? ~m_axis.tready[0] : 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis.tvalid[i]        = 1'b1;
        s_axis.tdata[8*i +: 8]  = src_q[i][0][7:0];
        s_axis.tlast[i]         = src_q[i][0][8];
      end else begin
        s_axis.tvalid[i] = 1'b0;
        s_axis.tlast[i]  = 1'b0;
      end
    end
    #1;
    if (stalled_prev) begin
      total++;
      if (m_axis.tvalid[0] !== 1'b1 || m_axis.tdata !== held_data || m_axis.tlast[0] !== held_last) begin
        bad++;
        $display("FAIL hold_stable got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                 m_axis.tvalid[0], m_axis.tdata, m_axis.tlast[0], held_data, held_last);
      end
    end
    stalled_prev = m_axis.tvalid[0] && !m_axis.tready[0];
    held_data    = m_axis.tdata;
    held_last    = m_axis.tlast[0];
    if (stalled_prev) begin
      total++;
      if (s_axis.tready !== '0) begin
        bad++;
        $display("FAIL ready_while_stalled got=%b required=000", s_axis.tready);
      end
    end
    total++;
    if (!$onehot0(s_axis.tready)) begin
      bad++;
      $display("FAIL ready_onehot got=%b required at most one bit", s_axis.tready);
    end
    if (mask_chk) begin
      total++;
      if (s_axis.tready[1] !== 1'b0) begin
        bad++;
        $display("FAIL masked_ready got=%b required=0", s_axis.tready[1]);
      end
    end
    if (stat_frame_forwarded) fwd_cnt++;
    if (stat_length_error)    err_cnt++;
    s_hs     = s_axis.tvalid & s_axis.tready;
    m_hs     = m_axis.tvalid[0] && m_axis.tready[0];
    m_data_s = m_axis.tdata;
    m_last_s = m_axis.tlast[0];
    m_dest_s = m_axis.tdest;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d bytes pending required=0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic check_counts(input string name, input int fwd_exp, input int err_exp);
    total++;
    if (fwd_cnt !== fwd_exp) begin
      bad++;
      $display("FAIL %s_forwarded got=%0d required=%0d", name, fwd_cnt, fwd_exp);
    end
    total++;
    if (err_cnt !== err_exp) begin
      bad++;
      $display("FAIL %s_length_error got=%0d required=%0d", name, err_cnt, err_exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({m_axis.tvalid[0], m_axis.tdata, m_axis.tlast[0], m_axis.tdest} !== '0) begin
      bad++;
      $display("FAIL %s_master got v=%0b d=%h l=%0b dest=%h required all 0",
               name, m_axis.tvalid[0], m_axis.tdata, m_axis.tlast[0], m_axis.tdest);
    end
    total++;
    if (s_axis.tready !== '0) begin
      bad++;
      $display("FAIL %s_s_ready got=%b required=000", name, s_axis.tready);
    end
    total++;
    if ({stat_frame_forwarded, stat_length_error, status_grant_active, dbg_state} !== 4'b0) begin
      bad++;
      $display("FAIL %s_status got=%b required=0000", name,
               {stat_frame_forwarded, stat_length_error, status_grant_active, dbg_state});
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    s_axis.tvalid = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    s_axis.tvalid = '0;
    rst = 1'b0;
  endtask

  task automatic test_contention();
    fwd_cnt = 0; err_cnt = 0;
    gap_chk = 1; have_prev = 0;
    push_frame(0, 6, 8'h10, 1);
    push_frame(1, 5, 8'h20, 1);
    push_frame(2, 7, 8'h30, 1);
    push_frame(0, 4, 8'h40, 1);
    drain(200);
    gap_chk = 0;
    check_counts("contention", 4, 0);
  endtask

  task automatic test_single_frame();
    logic [7:0] b [8] = '{8'h07, 8'h00, 8'hA1, 8'hD0, 8'h11, 8'h22, 8'h33, 8'h44};
    fwd_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 8; k++) push_byte(0, b[k], k == 7, 1);
    drain(100);
    check_counts("single", 1, 0);
  endtask

  task automatic test_backpressure();
    fwd_cnt = 0; err_cnt = 0;
    bp_mode = 1;
    push_frame(2, 10, 8'h50, 1);
    drain(200);
    bp_mode = 0;
    check_counts("backpressure", 1, 0);
  endtask

  task automatic test_length_error();
    logic [7:0] b [6] = '{8'h07, 8'h01, 8'hA2, 8'h10, 8'h20, 8'h30};
    fwd_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 6; k++) push_byte(1, b[k], k == 5, 1);
    push_frame(1, 1, 8'h00, 1);
    drain(100);
    check_counts("length", 2, 1);
    total++;
    if (status_grant_active !== 1'b0) begin
      bad++;
      $display("FAIL length_idle got=%0b required=0", status_grant_active);
    end
  endtask

  task automatic test_enable_mask();
    fwd_cnt = 0; err_cnt = 0;
    cfg_layer_enable = 3'b101;
    mask_chk = 1;
    push_frame(2, 5, 8'h60, 1);
    push_frame(0, 5, 8'h70, 1);
    push_frame(2, 4, 8'h80, 1);
    push_frame(0, 3, 8'h90, 1);
    push_frame(1, 5, 8'hA0, 0);
    push_frame(1, 5, 8'hA8, 0);
    drain(200);
    check_counts("mask", 4, 0);
    src_q[1].delete();
    step();
    mask_chk = 0;
    cfg_layer_enable = 3'b111;
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    fwd_cnt = 0; err_cnt = 0;
    l2_taken = 0;
    push_frame(2, 8, 8'hB0, 1);
    while (l2_taken < 3 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (l2_taken < 3 || m_axis.tvalid[0] !== 1'b1) begin
      bad++;
      $display("FAIL midframe_setup got taken=%0d valid=%0b required taken=3 valid=1", l2_taken, m_axis.tvalid[0]);
    end
    rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    for (int i = 0; i < NL; i++) src_q[i].delete();
    exp_q.delete();
    s_axis.tvalid = '0;
    s_axis.tlast  = '0;
    s_hs = '0; m_hs = 1'b0; stalled_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fwd_cnt = 0; err_cnt = 0;
    push_frame(0, 3, 8'hC0, 1);
    push_frame(1, 3, 8'hD0, 1);
    push_frame(2, 3, 8'hE0, 1);
    drain(100);
    check_counts("after_reset", 3, 0);
  endtask

  initial begin
    s_axis.tdata     = '0;
    s_axis.tvalid    = '0;
    s_axis.tlast     = '0;
    s_axis.tdest     = '0;
    m_axis.tready[0] = 1'b1;
    cfg_layer_enable = 3'b111;
    test_reset();
    test_contention();
    test_single_frame();
    test_backpressure();
    test_length_error();
    test_enable_mask();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
